// File: rtl/bf_fetch_decode.sv
//------------------------------------------------------------------------------
// Module   : bf_fetch_decode
// Brief    : Brainfuck fetch/decode stage: PC accept, sync ROM read, ASCII
//            decode, credit-controlled output FIFO, sticky HALT, flush.
//            Optional macro BF_SKIP_COMMENTS_EN drops NOP bytes before the FIFO.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module bf_fetch_decode #(
  parameter int DEPTH = 4,
  parameter int AW    = 9
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_in,
  input  logic          pc_valid,
  output logic          pc_ready,
  output logic [AW-1:0] imem_addr,
  output logic          imem_rd,
  input  logic [7:0]    imem_data,
  input  logic          flush,
  output logic [3:0]    op,
  output logic [AW-1:0] op_pc,
  output logic          op_valid,
  input  logic          op_ready,
  output logic          halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [0:0]    RUN      = 1'b0;
  localparam logic [0:0]    HALTED   = 1'b1;
  localparam logic [3:0]    OP_NOP   = 4'd0;
  localparam logic [3:0]    OP_HALT  = 4'd9;
  localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

  logic [0:0]    state;
  logic          s1_valid;
  logic [AW-1:0] s1_pc;
  logic [3:0]    mem_op [DEPTH];
  logic [AW-1:0] mem_pc [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [3:0]    dec_op;
  logic [CW:0]   occupancy;
  logic          accept;
  logic          push;
  logic          pop;

  always_comb begin
    dec_op = OP_NOP;
    case (imem_data)
      8'h3E:   dec_op = 4'd1;
      8'h3C:   dec_op = 4'd2;
      8'h2B:   dec_op = 4'd3;
      8'h2D:   dec_op = 4'd4;
      8'h2E:   dec_op = 4'd5;
      8'h2C:   dec_op = 4'd6;
      8'h5B:   dec_op = 4'd7;
      8'h5D:   dec_op = 4'd8;
      8'h00:   dec_op = OP_HALT;
      default: dec_op = OP_NOP;
    endcase
  end

  // Credit counts the op still sitting in s1 so the FIFO can never overflow.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, s1_valid};
  assign pc_ready  = (state == RUN) && !flush && (occupancy < DEPTH_LIM);
  assign accept    = pc_valid && pc_ready;
  assign imem_addr = pc_in;
  assign imem_rd   = accept && !rst;

`ifdef BF_SKIP_COMMENTS_EN
  assign push = s1_valid && !flush && (dec_op != OP_NOP);
`else
  assign push = s1_valid && !flush;
`endif

  assign op_valid = (count != '0) && !flush;
  assign pop      = op_valid && op_ready;
  assign op       = mem_op[rd_ptr];
  assign op_pc    = mem_pc[rd_ptr];
  assign halted   = (state == HALTED);

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    next_ptr = (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      s1_valid <= 1'b0;
      s1_pc    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (flush) begin
      state    <= RUN;
      s1_valid <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_pc <= pc_in;
      if (push && (dec_op == OP_HALT)) state <= HALTED;
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_op[i] <= '0;
        mem_pc[i] <= '0;
      end
    end else if (push) begin
      mem_op[wr_ptr] <= dec_op;
      mem_pc[wr_ptr] <= s1_pc;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bf_fetch_decode.sv
//------------------------------------------------------------------------------
// Module   : tb_bf_fetch_decode
// Brief    : Self-checking bench for bf_fetch_decode with a queue-based
//            reference model; honours BF_SKIP_COMMENTS_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_bf_fetch_decode;

  localparam int DEPTH = 4;
  localparam int AW    = 9;

  logic          sys_clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc_in;
  logic          pc_valid;
  logic          pc_ready;
  logic [AW-1:0] imem_addr;
  logic          imem_rd;
  logic [7:0]    imem_data = 8'h00;
  logic          flush;
  logic [3:0]    op;
  logic [AW-1:0] op_pc;
  logic          op_valid;
  logic          op_ready;
  logic          halted;

  bf_fetch_decode #(.DEPTH(DEPTH), .AW(AW)) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .pc_in     (pc_in),
    .pc_valid  (pc_valid),
    .pc_ready  (pc_ready),
    .imem_addr (imem_addr),
    .imem_rd   (imem_rd),
    .imem_data (imem_data),
    .flush     (flush),
    .op        (op),
    .op_pc     (op_pc),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .halted    (halted)
  );

  always #5 sys_clk = ~sys_clk;

  logic [7:0] rom [512];
  always @(posedge sys_clk) if (imem_rd) imem_data <= rom[imem_addr];

  typedef struct { int op; int pc; int stamp; } item_t;
  item_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc, delivered, accepted, halt_at;
  bit    halted_m, halt_pend, nop_pend, last_acc, skip_en;

`ifdef BF_SKIP_COMMENTS_EN
  initial skip_en = 1'b1;
`else
  initial skip_en = 1'b0;
`endif

  function automatic int ref_op(input logic [7:0] b);
    string cmds = "><+-.,[]";
    if (b == 8'h00) return 9;
    for (int i = 0; i < 8; i++) if (b == cmds[i]) return i + 1;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    nop_pend  = 1'b0;
    halt_pend = 1'b0;
    halted_m  = 1'b0;
  endtask

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int    live, o;
    bit    e_ready, e_valid;
    item_t it;
    @(negedge sys_clk);
    live    = exp_q.size() + int'(nop_pend);
    e_ready = !halted_m && !flush && (live < DEPTH);
    e_valid = !flush && (exp_q.size() > 0) && (exp_q[0].stamp < cyc);
    check("pc_ready", pc_ready, e_ready);
    check("imem_rd", imem_rd, pc_valid && e_ready);
    check("imem_addr", imem_addr, pc_in);
    check("op_valid", op_valid, e_valid);
    if (e_valid) begin
      check("op", op, exp_q[0].op);
      check("op_pc", op_pc, exp_q[0].pc);
    end
    check("halted", halted, halted_m);
    @(posedge sys_clk);
    cyc++;
    last_acc = 1'b0;
    if (flush) begin
      model_clear();
    end else begin
      if (halt_pend && cyc == halt_at) begin
        halted_m  = 1'b1;
        halt_pend = 1'b0;
      end
      if (e_valid && op_ready) begin
        exp_q.delete(0);
        delivered++;
      end
      nop_pend = 1'b0;
      if (pc_valid && e_ready) begin
        o = ref_op(rom[pc_in]);
        last_acc = 1'b1;
        accepted++;
        if (o == 9) begin
          halt_pend = 1'b1;
          halt_at   = cyc + 1;
        end
        if (skip_en && o == 0) nop_pend = 1'b1;
        else begin
          it.op = o; it.pc = int'(pc_in); it.stamp = cyc;
          exp_q.push_back(it);
        end
      end
    end
    #1;
  endtask

  task automatic run_stream(input int start, input int n, input int maxc);
    int cur = start;
    pc_valid = 1'b1;
    pc_in    = cur[AW-1:0];
    for (int k = 0; k < maxc; k++) begin
      cycle();
      if (last_acc) begin
        cur++;
        pc_in = cur[AW-1:0];
      end
      if (cur == start + n) pc_valid = 1'b0;
    end
    pc_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    pc_valid = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    string cmds = "><+-.,[]";
    int    r;
    for (int a = 0; a < 512; a++) rom[a] = 8'h20;
    rst = 1'b1; pc_valid = 1'b1; pc_in = '0; flush = 1'b0; op_ready = 1'b1;
    cyc = 0; delivered = 0; accepted = 0; halt_at = 0; last_acc = 1'b0;
    model_clear();
    #2;
    check("rst_op_valid", op_valid, 0);
    check("rst_op", op, 0);
    check("rst_op_pc", op_pc, 0);
    check("rst_pc_ready", pc_ready, 1);
    check("rst_imem_rd", imem_rd, 0);
    check("rst_halted", halted, 0);
    @(posedge sys_clk); @(posedge sys_clk); #1;
    rst = 1'b0; pc_valid = 1'b0;

    // Back-to-back program "+>.<"
    rom[0] = "+"; rom[1] = ">"; rom[2] = "."; rom[3] = "<";
    accepted = 0; delivered = 0;
    run_stream(0, 4, 4);
    drain(4);
    check("t1_accepted", accepted, 4);
    check("t1_delivered", delivered, 4);

    // Back-pressure: FIFO fills, credit stops the counter
    for (int a = 0; a < 10; a++) rom[a] = "+";
    accepted = 0; delivered = 0; op_ready = 1'b0;
    run_stream(0, 10, 10);
    check("t2_stall_accepts", accepted, 4);
    check("t2_head_valid", op_valid, 1);
    check("t2_head_pc", op_pc, 0);
    op_ready = 1'b1;
    run_stream(4, 6, 20);
    drain(6);
    check("t2_accepted", accepted, 10);
    check("t2_delivered", delivered, 10);

    // HALT at PC 5, follow-on PC 6 still delivered
    rom[5] = 8'h00; rom[6] = "+"; rom[7] = "-";
    accepted = 0; delivered = 0;
    run_stream(5, 3, 8);
    check("t3_accepted", accepted, 2);
    check("t3_halted", halted, 1);
    check("t3_delivered", delivered, 2);
    flush = 1'b1; cycle(); flush = 1'b0; cycle();
    check("t3_unhalted", halted, 0);
    check("t3_ready_back", pc_ready, 1);

    // Flush with 3 buffered + s1, then wrap-address accept
    for (int a = 30; a < 34; a++) rom[a] = "+";
    rom[9'h1FF] = "[";
    accepted = 0; op_ready = 1'b0;
    run_stream(30, 4, 4);
    check("t4_accepted", accepted, 4);
    flush = 1'b1; op_ready = 1'b1; pc_valid = 1'b1; pc_in = 9'h1FF;
    cycle();
    check("t4_flush_no_accept", last_acc, 0);
    flush = 1'b0; delivered = 0;
    cycle();
    check("t4_post_flush_accept", last_acc, 1);
    drain(4);
    check("t4_delivered", delivered, 1);

    // Comment byte handling
    rom[0] = "a"; rom[1] = "-";
    delivered = 0;
    run_stream(0, 2, 4);
    drain(4);
    check("t5_delivered", delivered, skip_en ? 1 : 2);

    // Asynchronous reset between edges
    rom[20] = 8'h00; rom[21] = "+"; rom[22] = ">";
    op_ready = 1'b0;
    run_stream(20, 2, 4);
    check("t6_pre_halted", halted, 1);
    check("t6_pre_valid", op_valid, 1);
    pc_valid = 1'b1; pc_in = 9'd22;
    #1 rst = 1'b1;
    #1;
    check("t6_rst_op_valid", op_valid, 0);
    check("t6_rst_halted", halted, 0);
    check("t6_rst_imem_rd", imem_rd, 0);
    #1 rst = 1'b0;
    model_clear();
    op_ready = 1'b1; delivered = 0;
    cycle();
    check("t6_first_accept", last_acc, 1);
    drain(4);
    check("t6_delivered", delivered, 1);

    // Randomized traffic with occasional flushes
    for (int a = 0; a < 512; a++) begin
      r = $urandom % 100;
      if (r < 2)       rom[a] = 8'h00;
      else if (r < 80) rom[a] = cmds[$urandom % 8];
      else             rom[a] = 8'($urandom);
    end
    for (int k = 0; k < 3000; k++) begin
      pc_in    = 9'($urandom_range(0, 511));
      pc_valid = ($urandom % 4) != 0;
      op_ready = ($urandom % 4) != 0;
      flush    = ($urandom % 64) == 0;
      cycle();
    end
    flush = 1'b0; op_ready = 1'b1;
    drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
